// File: rtl/spi_slave.sv
// SPI mode-0, MSB-first responder. Pins are synchronized into clk and one DATA_WIDTH frame is shifted per ss_n assertion.
// Optional macro SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse output for aborted or over-clocked frames.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    ss_prev_q, ss_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_ready_q, tx_ready_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                    frame_err_q, frame_err_d;
  logic                    extra_q, extra_d;
`endif

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    cnt_d       = cnt_q;
    hold_d      = tx_load ? tx_data : hold_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = tx_ready_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
    extra_d     = extra_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
        extra_d = 1'b0;
`endif
        if (ss_fall) begin
          tx_shift_d = hold_q;
          cnt_d      = '0;
          tx_ready_d = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // A full count wins over a coincident ss_n rise so a complete frame is never dropped.
        if (cnt_q == CNT_FULL) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = ss_rise ? IDLE : HOLD;
        end else if (ss_rise) begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_d = (cnt_q != '0);
`endif
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            cnt_d      = cnt_q + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (sclk_rise && !extra_q) begin
          frame_err_d = 1'b1;
          extra_d     = 1'b1;
        end
`endif
        if (ss_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in the same cycle as frame start still leaves the new word pending.
    if (tx_load) begin
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      hold_q      <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
      extra_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
      extra_q     <= extra_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = (state_q != IDLE);
  assign miso     = (!ss_s && state_q != IDLE) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master plus a word-level model of what the responder must return and deliver.
module tb_spi_slave;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_load;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic          miso;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic          frame_err;
`endif

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] hold_m;
  logic [DW-1:0] last_rx;
  logic [DW-1:0] exp_q[$];
  int            exp_fe = 0;
  int            fe_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: rx_data only changes with a pulse that delivers the next expected word.
  int   ss_hi = 0;
  int   ss_lo = 0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset rx_data", rx_data, 0);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset miso", miso, 0);
      chk("reset tx_ready", tx_ready, 1);
      last_rx  = '0;
      prev_vld = 1'b0;
      ss_hi    = 0;
      ss_lo    = 0;
    end else begin
      if (rx_valid) begin
        chk("rx_valid spacing", prev_vld, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected rx_valid", 1, 0);
        end else begin
          last_rx = exp_q.pop_front();
          chk("rx_data at valid", rx_data, last_rx);
        end
      end else begin
        chk("rx_data stable", rx_data, last_rx);
      end
      prev_vld = rx_valid;
      if (ss_n) begin ss_hi++; ss_lo = 0; end
      else begin ss_lo++; ss_hi = 0; end
      if (ss_hi >= 6) begin
        chk("idle busy", busy, 0);
        chk("idle miso", miso, 0);
      end
      if (ss_lo >= 6) chk("selected busy", busy, 1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) fe_seen++;
`endif
    end
  end

  task automatic load(input logic [DW-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
    hold_m  = w;
    chk("tx_ready after load", tx_ready, 0);
  endtask

  // One ss_n assertion with np sclk pulses; got is the word the master sees on miso.
  task automatic frame(input logic [DW-1:0] mo, input int np, input bit rst_mid,
                       input bit load_mid, input logic [DW-1:0] mid_w, output logic [DW-1:0] got);
    logic [DW-1:0] exp_tx;
    int nb;
    exp_tx = hold_m;
    got    = '0;
    if (np >= DW && !rst_mid) exp_q.push_back(mo);
    if (!rst_mid && ((np > 0 && np < DW) || np > DW)) exp_fe++;
    ss_n = 1'b0;
    clks(6);
    chk("tx_ready after ss fall", tx_ready, 1);
    for (int i = 0; i < np; i++) begin
      mosi = (i < DW) ? mo[DW-1-i] : 1'($urandom);
      clks(2);
      sclk = 1'b1;
      if (i < DW) got[DW-1-i] = miso;
      if (load_mid && i == 2) begin
        load(mid_w);
        clks(4);
      end else begin
        clks(5);
      end
      sclk = 1'b0;
      clks(5);
      if (rst_mid && i == 3) begin
        rst_n = 1'b0;
        #1;
        chk("async reset miso", miso, 0);
        chk("async reset busy", busy, 0);
        chk("async reset rx_data", rx_data, 0);
        chk("async reset tx_ready", tx_ready, 1);
        ss_n   = 1'b1;
        mosi   = 1'b0;
        hold_m = '0;
        clks(3);
        rst_n = 1'b1;
        clks(8);
        return;
      end
    end
    clks(3);
    ss_n = 1'b1;
    clks(8);
    nb = (np < DW) ? np : DW;
    for (int i = 0; i < nb; i++) chk("miso bit", got[DW-1-i], exp_tx[DW-1-i]);
    chk("rx_valid count", exp_q.size(), 0);
    chk("busy after frame", busy, 0);
  endtask

  logic [DW-1:0] got;
  int            r;
  int            np;

  initial begin
    rst_n   = 1'b0;
    sclk    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    hold_m  = '0;
    last_rx = '0;
    clks(3);
    chk("reset miso pin", miso, 0);
    rst_n = 1'b1;
    clks(4);

    load(8'hA5);
    frame(8'h3C, 8, 0, 0, 8'h00, got);
    chk("f1 master word", got, 8'hA5);
    chk("f1 rx_data", rx_data, 8'h3C);
    chk("f1 tx_ready", tx_ready, 1);

    frame(8'h81, 8, 0, 0, 8'h00, got);
    chk("f2 resent word", got, 8'hA5);
    chk("f2 rx_data", rx_data, 8'h81);

    frame(8'h77, 8, 0, 1, 8'h5A, got);
    chk("f3 word during load", got, 8'hA5);
    chk("f3 tx_ready", tx_ready, 0);
    frame(8'h12, 8, 0, 0, 8'h00, got);
    chk("f4 new word", got, 8'h5A);
    chk("f4 rx_data", rx_data, 8'h12);

    frame(8'hC3, 3, 0, 0, 8'h00, got);
    chk("abort rx_data", rx_data, 8'h12);
    frame(8'h34, 8, 0, 0, 8'h00, got);
    chk("post-abort word", got, 8'h5A);
    chk("post-abort rx_data", rx_data, 8'h34);

    frame(8'hE7, 10, 0, 0, 8'h00, got);
    chk("overclock rx_data", rx_data, 8'hE7);

    frame(8'hF0, 8, 1, 0, 8'h00, got);
    chk("post-reset rx_data", rx_data, 0);
    load(8'h96);
    frame(8'h69, 8, 0, 0, 8'h00, got);
    chk("post-reset word", got, 8'h96);
    chk("post-reset rx", rx_data, 8'h69);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) load(DW'($urandom));
      r = $urandom_range(0, 3);
      if (r == 0)      np = $urandom_range(1, DW - 1);
      else if (r == 3) np = DW + $urandom_range(1, 3);
      else             np = DW;
      frame(DW'($urandom), np, 0, ($urandom_range(0, 3) == 0), DW'($urandom), got);
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("frame_err pulses", fe_seen, exp_fe);
`endif
    chk("pending words", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder for the team's existing SPI initiator. It samples the off-chip sclk, ss_n and mosi pins into the system clock domain and shifts one DATA_WIDTH-bit frame per ss_n assertion. It returns a preloaded response word on miso and presents each received word to local logic with a one-cycle valid pulse. It sits at the chip pad boundary, opposite the master, in peripheral designs.

Parameters:
DATA_WIDTH, 8, frame length in bits (>=2)
SYNC_STAGES, 2, flop stages in each input synchronizer (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  response word for a future frame
tx_load  input  1  one-cycle strobe; latches tx_data into the holding register
tx_ready  output  1  holding register consumed; new tx_data may be loaded
rx_data  output  DATA_WIDTH  last completely received word
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  frame in progress (state != IDLE)
sclk  input  1  serial clock from master, asynchronous to clk
ss_n  input  1  active-low select from master, asynchronous
mosi  input  1  serial data from master
miso  output  1  serial data to master

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0. Holding and shift registers = 0. Synchronizer reset values: sclk 0, ss_n 1, mosi 0.
- sclk, ss_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and ss_n.
- Interface constraint: each sclk phase lasts >=4 clk cycles. The master presents mosi at least 1 clk before the sclk rise.
- FSM has three states: IDLE, SHIFT, HOLD.
- IDLE:
  - On a synchronized ss_n fall: load the shift register from the holding register, clear the 0..DATA_WIDTH bit counter, set tx_ready=1, go to SHIFT.
- SHIFT:
  - On a synchronized sclk rise: shift the synced mosi into the LSB of the rx shift register and increment the counter.
  - On a synchronized sclk fall: shift the tx register left by 1.
  - When the counter reaches DATA_WIDTH (on the rising-edge cycle): on the next clk, rx_data <= rx shift register and rx_valid=1 for exactly one clk; go to HOLD.
- HOLD: sclk edges are ignored. On a synchronized ss_n rise, go to IDLE.
- Abort: a synchronized ss_n rise while in SHIFT returns to IDLE. The counter is cleared, rx_valid does not pulse, and rx_data is unchanged.
- miso equals tx shift[DATA_WIDTH-1] while the synced ss_n is low and state != IDLE; otherwise miso=0 (no tristate). Bit 0 is valid before the first sclk rise.
- tx_load:
  - Writes the holding register in any state and clears tx_ready on the next clk. It never disturbs a frame in progress.
  - If no tx_load arrives between frames, the holding register retains its value and the same word is resent.
  - If tx_load and an ss_n fall occur in the same cycle, the old holding value is shifted out, the new value is stored, and tx_ready=0.
- rx_valid is never back-to-back; the minimum spacing is one frame.
- Asserting rst_n low mid-frame returns all outputs to their reset values immediately (asynchronously). A frame cut by reset is lost.
- Counter width is $clog2(DATA_WIDTH)+1. No wrap is possible because HOLD blocks extra edges.

Optional Feature:
SPI_SLAVE_FRAME_ERR_EN:
- Defined: adds output frame_err (1 bit, reset 0). It pulses for one clk when a synchronized ss_n rise occurs in SHIFT with counter 1..DATA_WIDTH-1, or when more than zero sclk rises arrive in HOLD. An ss_n pulse with zero sclk edges is not an error.
- Undefined: the port is absent, and aborts and extra edges are silently discarded.

Test Plan:
- Reset, then tx_load tx_data=8'hA5. Master sends 8'h3C -> master receives 8'hA5; rx_data=8'h3C; one rx_valid pulse; tx_ready 0 after load, then 1 after the ss_n fall.
- Second frame with no new tx_load; master sends 8'h81 -> miso again returns 8'hA5; rx_data=8'h81.
- tx_load 8'h5A during a busy frame (sending 8'hA5) -> the current frame still returns A5; the next frame returns 5A.
- Abort after 3 sclk rises -> no rx_valid, rx_data unchanged, busy=0. The next full frame works normally (frame_err pulses once if the feature is enabled).
- 10 sclk pulses in one ss_n assertion -> exactly one rx_valid pulse, carrying the first 8 bits; extra edges ignored.
- rst_n asserted mid-frame after 4 bits -> miso=0, busy=0, rx_data=0 immediately; the following frame completes correctly.
